// File: rtl/sbcfg_pkg.sv
// Shared definitions for the switch-box configuration loader.
//   CFG_W          width of one switch-box config word and of the checksum
//   BIT_CNT_W      width of the deserialiser bit counter
//   sbcfg_state_t  controller FSM states
//   idx_width()    width of a word index for n boxes (never below 1)
package sbcfg_pkg;

  localparam int CFG_W     = 16;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WRITE   = 3'd2,
    CK_LOAD = 3'd3,
    COMPARE = 3'd4
  } sbcfg_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sbcfg_deser.sv
// 16-bit LSB-first serial-to-parallel converter.
//   clk, reset  clock (rising edge), asynchronous active-high reset
//   clr         synchronous clear of word and bit counter (wins over shift_en)
//   shift_en    accept bit_in into word[bit_cnt] this cycle
//   bit_in      serial data
//   word        assembled word
//   last        this accepted bit completes a word (bit_cnt==15 and shift_en)
module sbcfg_deser
  import sbcfg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CFG_W-1:0] word,
  output logic             last
);

  logic [BIT_CNT_W-1:0] bit_cnt;

  // The counter is exactly 4 bits, so the 16th bit wraps it back to 0 and
  // the next word starts cleanly without an explicit reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      word[bit_cnt] <= bit_in;
      bit_cnt       <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  assign last = shift_en && (bit_cnt == BIT_CNT_W'(CFG_W - 1));

endmodule

// File: rtl/sb_config_ctrl.sv
// Switch-box configuration sequencer. Deserialises a config bitstream into
// NUM_SB 16-bit words, writes word i to switch box i, then checks a trailing
// 16-bit XOR checksum; a mismatch or an abort clears every switch box.
//   clk, reset  clock (rising edge), asynchronous active-high reset
//   start       begin a load (sampled only in IDLE)
//   abort       abandon a load in progress (ignored in IDLE)
//   cfg_valid   cfg_bit is valid this cycle
//   cfg_bit     serial config data, LSB of each word first
//   cfg_ready   controller accepts cfg_bit this cycle
//   sb_we       one-hot write strobe per switch box
//   sb_wdata    config word for the strobed box, 0 when no strobe
//   sb_clr      one-cycle clear of all switch-box registers
//   busy        controller is not IDLE
//   done, err   result of the last load, cleared by the next start
//
// Handshake: a bit transfers on a rising edge where cfg_valid and cfg_ready
// are both high; cfg_ready is high only in LOAD and CK_LOAD, and a cycle with
// cfg_valid low is a stall that changes nothing.
module sb_config_ctrl
  import sbcfg_pkg::*;
#(
  parameter int NUM_SB = 4,
  parameter int IDX_W  = idx_width(NUM_SB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  output logic [NUM_SB-1:0] sb_we,
  output logic [CFG_W-1:0]  sb_wdata,
  output logic              sb_clr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  sbcfg_state_t     state;
  sbcfg_state_t     state_next;
  logic [IDX_W-1:0] word_idx;
  logic [CFG_W-1:0] csum;
  logic [CFG_W-1:0] shreg;
  logic             last_bit;
  logic             shift_en;
  logic             abort_hit;
  logic             launch;
  logic             write_en;
  logic             last_word;
  logic             match;

  assign busy      = (state != IDLE);
  assign abort_hit = abort && busy;
  assign launch    = (state == IDLE) && start;
  assign cfg_ready = (state == LOAD) || (state == CK_LOAD);
  // An abort suppresses the transfer so nothing moves on the way to IDLE.
  assign shift_en  = cfg_valid && cfg_ready && !abort;
  assign write_en  = (state == WRITE) && !abort;
  assign last_word = (word_idx == IDX_W'(NUM_SB - 1));
  assign match     = (shreg == csum);

  sbcfg_deser u_deser (
    .clk      (clk),
    .reset    (reset),
    .clr      (launch || abort_hit),
    .shift_en (shift_en),
    .bit_in   (cfg_bit),
    .word     (shreg),
    .last     (last_bit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (last_bit) state_next = WRITE;
      WRITE:   state_next = last_word ? CK_LOAD : LOAD;
      CK_LOAD: if (last_bit) state_next = COMPARE;
      COMPARE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  always_comb begin
    sb_we = '0;
    for (int i = 0; i < NUM_SB; i++) begin
      sb_we[i] = write_en && (word_idx == IDX_W'(i));
    end
  end

  assign sb_wdata = write_en ? shreg : '0;
  assign sb_clr   = abort_hit || ((state == COMPARE) && !match);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_idx <= '0;
      csum     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      if (launch) begin
        done     <= 1'b0;
        err      <= 1'b0;
        word_idx <= '0;
        csum     <= '0;
      end else if (abort_hit) begin
        err <= 1'b1;
      end else begin
        case (state)
          WRITE: begin
            csum <= csum ^ shreg;
            if (!last_word) word_idx <= word_idx + IDX_W'(1);
          end
          COMPARE: begin
            if (match) done <= 1'b1;
            else       err  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sb_config_ctrl.sv
module tb_sb_config_ctrl;
  import sbcfg_pkg::*;

  localparam int NUM_SB = 4;
  localparam int EW     = 32 + 1 + NUM_SB + CFG_W;

  typedef logic [CFG_W-1:0] word_arr_t [NUM_SB];

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_bit = 1'b0;
  logic              cfg_ready;
  logic [NUM_SB-1:0] sb_we;
  logic [CFG_W-1:0]  sb_wdata;
  logic              sb_clr;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // expected output events: {cycle, clr, we, wdata}
  logic [EW-1:0] exp_q[$];

  sb_config_ctrl #(.NUM_SB(NUM_SB)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_ready(cfg_ready),
    .sb_we(sb_we), .sb_wdata(sb_wdata), .sb_clr(sb_clr),
    .busy(busy), .done(done), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input int c, input logic clr, input logic [NUM_SB-1:0] we,
                          input logic [CFG_W-1:0] data);
    exp_q.push_back({c[31:0], clr, we, data});
  endtask

  task automatic stall_cycle();
    cfg_valid = 1'b0;
    cfg_bit   = 1'($urandom);
    start     = 1'($urandom);
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic stray_start);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    start     = stray_start;
    check("cfg_ready", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  // stall_mode: 0 none, 1 valid toggling 1,0,1,0 in word 0, 2 random stalls
  // abort_word < 0: no abort; otherwise abort before bit abort_bit of that word
  task automatic run_load(input word_arr_t words, input logic [CFG_W-1:0] ck,
                          input int stall_mode, input int abort_word, input int abort_bit,
                          input logic check_len);
    logic [CFG_W-1:0] sum;
    int start_cyc;
    sum = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", busy, 1'b1);
    check("done_cleared", done, 1'b0);
    check("err_cleared", err, 1'b0);
    for (int i = 0; i < NUM_SB; i++) begin
      for (int j = 0; j < CFG_W; j++) begin
        if (i == abort_word && j == abort_bit) begin
          abort     = 1'b1;
          cfg_valid = 1'b1;
          cfg_bit   = 1'($urandom);
          push_evt(cyc, 1'b1, '0, '0);
          tick();
          abort     = 1'b0;
          cfg_valid = 1'b0;
          check("abort_busy", busy, 1'b0);
          check("abort_err", err, 1'b1);
          check("abort_done", done, 1'b0);
          return;
        end
        if (stall_mode == 2 && $urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) stall_cycle();
        end
        send_bit(words[i][j], 1'($urandom));
        if (stall_mode == 1 && i == 0 && j < CFG_W - 1) stall_cycle();
      end
      // the WRITE cycle follows the edge that took the 16th bit
      push_evt(cyc, 1'b0, NUM_SB'(1) << i, words[i]);
      sum = sum ^ words[i];
      cfg_valid = 1'($urandom);
      start     = 1'($urandom);
      tick();
      cfg_valid = 1'b0;
      start     = 1'b0;
    end
    for (int j = 0; j < CFG_W; j++) begin
      if (stall_mode == 2 && $urandom_range(0, 3) == 0) stall_cycle();
      send_bit(ck[j], 1'($urandom));
    end
    if (ck != sum) push_evt(cyc, 1'b1, '0, '0);
    tick();
    if (check_len) check("load_cycles", cyc - start_cyc, NUM_SB * 17 + 17);
    check("end_busy", busy, 1'b0);
    check("end_done", done, ck == sum);
    check("end_err", err, ck != sum);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      if (sb_we == '0) check("wdata_zero_idle", sb_wdata, '0);
      if (sb_we != '0 || sb_clr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: cycle %0d we %b clr %b wdata %h, expected no event",
                   cyc, sb_we, sb_clr, sb_wdata);
        end else begin
          e = exp_q.pop_front();
          check("evt_cycle", cyc, e[EW-1 -: 32]);
          check("evt_clr", sb_clr, e[NUM_SB + CFG_W]);
          check("evt_we", sb_we, e[CFG_W +: NUM_SB]);
          check("evt_wdata", sb_wdata, e[CFG_W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    word_arr_t w;
    logic [CFG_W-1:0] sum;
    #12;
    check("rst_cfg_ready", cfg_ready, 1'b0);
    check("rst_sb_we", sb_we, '0);
    check("rst_sb_wdata", sb_wdata, '0);
    check("rst_sb_clr", sb_clr, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    w[0] = 16'hA5A5; w[1] = 16'h0001; w[2] = 16'hFFFF; w[3] = 16'h1234;
    sum = 16'hA5A5 ^ 16'h0001 ^ 16'hFFFF ^ 16'h1234;

    // good load, stray start pulses while busy
    run_load(w, sum, 0, -1, 0, 1'b1);
    tick();
    // bad checksum
    run_load(w, 16'h0000, 0, -1, 0, 1'b0);
    tick();
    // valid toggling in word 0
    run_load(w, sum, 1, -1, 0, 1'b0);
    // abort after 8 bits of word 2, then a good load
    run_load(w, sum, 0, 2, 8, 1'b0);
    tick();
    run_load(w, sum, 2, -1, 0, 1'b0);

    // randomized loads: random words, stalls, checksum good or bad, occasional abort
    for (int n = 0; n < 8; n++) begin
      logic [CFG_W-1:0] ck;
      sum = '0;
      for (int i = 0; i < NUM_SB; i++) begin
        w[i] = CFG_W'($urandom);
        sum  = sum ^ w[i];
      end
      ck = ($urandom_range(0, 1) == 0) ? sum : (sum ^ CFG_W'($urandom_range(1, 65535)));
      if ($urandom_range(0, 3) == 0)
        run_load(w, ck, 2, $urandom_range(0, NUM_SB - 1), $urandom_range(0, CFG_W - 1), 1'b0);
      else
        run_load(w, ck, 2, -1, 0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // asynchronous reset during the WRITE cycle of word 1
    w[0] = 16'hC3C3; w[1] = 16'h5A5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < CFG_W; j++) send_bit(w[0][j], 1'b0);
    push_evt(cyc, 1'b0, NUM_SB'(1), w[0]);
    tick();
    for (int j = 0; j < CFG_W; j++) send_bit(w[1][j], 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_sb_we", sb_we, '0);
    check("mid_rst_sb_wdata", sb_wdata, '0);
    check("mid_rst_sb_clr", sb_clr, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cfg_ready", cfg_ready, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", err, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    w[0] = 16'hA5A5; w[1] = 16'h0001; w[2] = 16'hFFFF; w[3] = 16'h1234;
    sum = 16'hA5A5 ^ 16'h0001 ^ 16'hFFFF ^ 16'h1234;
    run_load(w, sum, 0, -1, 0, 1'b1);
    repeat (3) tick();

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
